// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and halt controller for a short in-order pipeline: load-use stalls,
// branch/jump flushes, a three-cycle HLT drain, and saturating event counters.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  id_opcode,
  input  logic [5:0]  id_func_code,
  input  logic [1:0]  id_rs1,
  input  logic [1:0]  id_rs2,
  input  logic        ex_mem_read,
  input  logic [1:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        wb_valid,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halt,
  output logic [15:0] num_inst,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // Opcode and function encodings shared with the rest of the core.
  localparam logic [3:0] BNE_OP = 4'd0;
  localparam logic [3:0] BEQ_OP = 4'd1;
  localparam logic [3:0] LHI_OP = 4'd6;
  localparam logic [3:0] SWD_OP = 4'd8;
  localparam logic [3:0] JMP_OP = 4'd9;
  localparam logic [3:0] JAL_OP = 4'd10;
  localparam logic [3:0] ALU_OP = 4'd15;

  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_JPR = 6'd25;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0] state_r;
  logic [1:0] next_state_s;
  logic [1:0] dcnt_r;
  logic [1:0] next_dcnt_s;
  logic       rs1_used_s;
  logic       rs2_used_s;
  logic       load_use_s;
  logic       is_hlt_s;
  logic       is_jmp_s;
  logic       stall_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
    if (en && (val != 16'hFFFF)) begin
      sat_inc = val + 16'd1;
    end else begin
      sat_inc = val;
    end
  endfunction

  // Decode register usage and control-flow class of the ID instruction.
  always_comb begin
    rs1_used_s = !((id_opcode == LHI_OP) || (id_opcode == JMP_OP) || (id_opcode == JAL_OP));
    rs2_used_s = 1'b0;
    is_hlt_s   = 1'b0;
    is_jmp_s   = 1'b0;
    case (id_opcode)
      ALU_OP: begin
        case (id_func_code)
          FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR: rs2_used_s = 1'b1;
          FUNC_JPR, FUNC_JRL:                     is_jmp_s   = 1'b1;
          FUNC_HLT:                               is_hlt_s   = 1'b1;
          default:                                rs2_used_s = 1'b0;
        endcase
      end
      SWD_OP, BNE_OP, BEQ_OP: rs2_used_s = 1'b1;
      JMP_OP, JAL_OP:         is_jmp_s   = 1'b1;
      default:                rs2_used_s = 1'b0;
    endcase
    load_use_s = ex_mem_read &&
                 ((rs1_used_s && (id_rs1 == ex_rd)) || (rs2_used_s && (id_rs2 == ex_rd)));
  end

  // Pipeline control outputs and next-state selection; reset reads as a frozen pipe.
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b1;
    next_state_s = state_r;
    next_dcnt_s  = dcnt_r;
    stall_s      = 1'b0;
    if (!reset_n) begin
      next_state_s = RUN;
      next_dcnt_s  = 2'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_branch_taken) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
          end else if (load_use_s) begin
            stall_s = 1'b1;
          end else if (is_hlt_s) begin
            idex_bubble  = 1'b0;
            next_state_s = DRAIN;
            next_dcnt_s  = 2'd3;
          end else if (is_jmp_s) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b0;
          end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b0;
          end
        end
        // A branch in EX here is younger than the HLT, so it is deliberately ignored.
        DRAIN: begin
          next_dcnt_s = dcnt_r - 2'd1;
          if (dcnt_r == 2'd1) begin
            next_state_s = HALTED;
          end else begin
            next_state_s = DRAIN;
          end
        end
        HALTED: begin
          next_state_s = HALTED;
        end
        default: begin
          next_state_s = RUN;
          next_dcnt_s  = 2'd0;
        end
      endcase
    end
  end

  // State, drain counter, halt flag and saturating counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= RUN;
      dcnt_r    <= 2'd0;
      halt      <= 1'b0;
      num_inst  <= 16'd0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      state_r   <= next_state_s;
      dcnt_r    <= next_dcnt_s;
      halt      <= (next_state_s == HALTED);
      num_inst  <= sat_inc(num_inst, wb_valid);
      stall_cnt <= sat_inc(stall_cnt, stall_s);
      flush_cnt <= sat_inc(flush_cnt, ifid_flush);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed steps queue hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] ADI = 4'd4;
  localparam logic [3:0] LHI = 4'd6;
  localparam logic [3:0] JMP = 4'd9;
  localparam logic [3:0] ALU = 4'd15;
  localparam logic [5:0] F_ADD = 6'd0;
  localparam logic [5:0] F_JPR = 6'd25;
  localparam logic [5:0] F_HLT = 6'd29;

  logic        clk;
  logic        reset_n;
  logic [3:0]  id_opcode;
  logic [5:0]  id_func_code;
  logic [1:0]  id_rs1;
  logic [1:0]  id_rs2;
  logic        ex_mem_read;
  logic [1:0]  ex_rd;
  logic        ex_branch_taken;
  logic        wb_valid;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        halt;
  logic [15:0] num_inst;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  typedef struct {
    string       name;
    logic [3:0]  cmb;
    logic        hlt;
    logic [15:0] ni;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .id_opcode(id_opcode), .id_func_code(id_func_code),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .wb_valid(wb_valid),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .halt(halt),
    .num_inst(num_inst), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rn, input logic [3:0] op, input logic [5:0] fn,
                       input logic [1:0] r1, input logic [1:0] r2, input logic mr,
                       input logic [1:0] rd, input logic br, input logic wb);
    reset_n         = rn;
    id_opcode       = op;
    id_func_code    = fn;
    id_rs1          = r1;
    id_rs2          = r2;
    ex_mem_read     = mr;
    ex_rd           = rd;
    ex_branch_taken = br;
    wb_valid        = wb;
  endtask

  // cmb = {pc_write, ifid_write, ifid_flush, idex_bubble}
  task automatic step(input string nm, input logic rn, input logic [3:0] op,
                      input logic [5:0] fn, input logic [1:0] r1, input logic [1:0] r2,
                      input logic mr, input logic [1:0] rd, input logic br, input logic wb,
                      input logic [3:0] cmb, input logic h,
                      input logic [15:0] ni, input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    drive(rn, op, fn, r1, r2, mr, rd, br, wb);
    e.name = nm;
    e.cmb  = cmb;
    e.hlt  = h;
    e.ni   = ni;
    e.sc   = sc;
    e.fc   = fc;
    sb.push_back(e);
  endtask

  // Monitor: compare one queued expectation per falling edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_write, ifid_write, ifid_flush, idex_bubble};
      n_cmp++;
      if (act !== e.cmb || halt !== e.hlt || num_inst !== e.ni ||
          stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        n_fail++;
        $display("FAIL %s: got pw/iw/fl/bb=%b halt=%b ni=%h sc=%h fc=%h, want %b halt=%b ni=%h sc=%h fc=%h",
                 e.name, act, halt, num_inst, stall_cnt, flush_cnt,
                 e.cmb, e.hlt, e.ni, e.sc, e.fc);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    drive(1'b0, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);

    step("reset",          1'b0, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd0, 16'd0, 16'd0);
    step("run_plain",      1'b1, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1100, 1'b0, 16'd0, 16'd0, 16'd0);
    step("load_use_rs2",   1'b1, ALU, F_ADD, 2'd0, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd1, 16'd0, 16'd0);
    step("after_stall",    1'b1, ALU, F_ADD, 2'd0, 2'd2, 1'b0, 2'd2, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd1, 16'd1, 16'd0);
    step("lhi_no_use",     1'b1, LHI, F_ADD, 2'd2, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd1, 16'd1, 16'd0);
    step("adi_rs1_use",    1'b1, ADI, F_ADD, 2'd3, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd1, 16'd1, 16'd0);
    step("adi_rs2_unused", 1'b1, ADI, F_ADD, 2'd0, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd1, 16'd2, 16'd0);
    step("branch_over_lu", 1'b1, ALU, F_ADD, 2'd0, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 4'b1111, 1'b0, 16'd1, 16'd2, 16'd0);
    step("post_branch",    1'b1, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd2, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd1, 16'd2, 16'd1);
    step("jmp_flush",      1'b1, JMP, F_ADD, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1110, 1'b0, 16'd1, 16'd2, 16'd1);
    step("jpr_flush",      1'b1, ALU, F_JPR, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1110, 1'b0, 16'd1, 16'd2, 16'd2);
    step("branch_hlt",     1'b1, ALU, F_HLT, 2'd1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1111, 1'b0, 16'd1, 16'd2, 16'd3);
    step("lu_hlt_stall",   1'b1, ALU, F_HLT, 2'd1, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd1, 16'd2, 16'd4);
    step("hlt_enter",      1'b1, ALU, F_HLT, 2'd1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1, 16'd3, 16'd4);
    step("drain1_br_ign",  1'b1, ALU, F_HLT, 2'd1, 2'd0, 1'b0, 2'd1, 1'b1, 1'b1, 4'b0001, 1'b0, 16'd1, 16'd3, 16'd4);
    step("drain2",         1'b1, ALU, F_HLT, 2'd1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1, 4'b0001, 1'b0, 16'd2, 16'd3, 16'd4);
    step("drain3",         1'b1, ALU, F_HLT, 2'd1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd3, 16'd3, 16'd4);
    step("halted",         1'b1, ALU, F_ADD, 2'd0, 2'd1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0001, 1'b1, 16'd3, 16'd3, 16'd4);
    step("halted_wb",      1'b1, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1, 4'b0001, 1'b1, 16'd3, 16'd3, 16'd4);
    step("halted_hold",    1'b1, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0001, 1'b1, 16'd4, 16'd3, 16'd4);
    step("reset_halted",   1'b0, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd0, 16'd0, 16'd0);
    step("post_reset_run", 1'b1, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1, 4'b1100, 1'b0, 16'd0, 16'd0, 16'd0);

    // Preload num_inst well past its saturation point.
    @(posedge clk);
    #1;
    drive(1'b1, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1);
    repeat (65540) @(posedge clk);

    step("saturated",      1'b1, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1100, 1'b0, 16'hFFFF, 16'd0, 16'd0);
    step("sat_hold",       1'b1, ALU, F_HLT, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 16'hFFFF, 16'd0, 16'd0);
    step("sat_drain",      1'b1, ALU, F_HLT, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0001, 1'b0, 16'hFFFF, 16'd0, 16'd0);
    step("reset_mid_drain",1'b0, ALU, F_HLT, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd0, 16'd0, 16'd0);
    step("run_after_rst",  1'b1, ALU, F_ADD, 2'd0, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd0, 16'd0, 16'd0);
    step("stall_after_rst",1'b1, ALU, F_ADD, 2'd0, 2'd1, 1'b0, 2'd2, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd0, 16'd1, 16'd0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() > 0) begin
      $display("FAIL drain_queue: %0d expectations never compared, want 0", sb.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
